// File: rtl/lpif_tx_arbiter_if.sv
// lpif_tx_arbiter_if: LPIF transmit bundle between packet generators, arbiter and PHY.
// Signals: TLP source (tlp_data/valid/req/last, tlp_gnt), DLLP source (dllp_data/valid/req, dllp_gnt),
// LPIF side (data/valid/irdy, trdy), stall handshake (stall_req/stall_ack), link_up, tlp_abort,
// packet counters (tlp_pkt_cnt/dllp_pkt_cnt). slave = arbiter view, master = environment view.
interface lpif_tx_arbiter_if #(
    parameter int DATA_BYTES = 8
);
    logic [DATA_BYTES*8-1:0] tlp_data;
    logic [DATA_BYTES-1:0]   tlp_valid;
    logic                    tlp_req;
    logic                    tlp_last;
    logic                    tlp_gnt;
    logic [DATA_BYTES*8-1:0] dllp_data;
    logic [DATA_BYTES-1:0]   dllp_valid;
    logic                    dllp_req;
    logic                    dllp_gnt;
    logic [DATA_BYTES*8-1:0] data;
    logic [DATA_BYTES-1:0]   valid;
    logic                    irdy;
    logic                    trdy;
    logic                    stall_req;
    logic                    stall_ack;
    logic                    link_up;
    logic                    tlp_abort;
    logic [15:0]             tlp_pkt_cnt;
    logic [15:0]             dllp_pkt_cnt;

    modport slave (
        input  tlp_data, tlp_valid, tlp_req, tlp_last, dllp_data, dllp_valid, dllp_req,
               trdy, stall_req, link_up,
        output tlp_gnt, dllp_gnt, data, valid, irdy, stall_ack, tlp_abort, tlp_pkt_cnt, dllp_pkt_cnt
    );

    modport master (
        output tlp_data, tlp_valid, tlp_req, tlp_last, dllp_data, dllp_valid, dllp_req,
               trdy, stall_req, link_up,
        input  tlp_gnt, dllp_gnt, data, valid, irdy, stall_ack, tlp_abort, tlp_pkt_cnt, dllp_pkt_cnt
    );
endinterface

// File: rtl/lpif_tx_arbiter.sv
// lpif_tx_arbiter: shares one LPIF transmit beat between a TLP source and a DLLP source.
// Ports: clk (LPIF clock), reset (async, active low), bus (lpif_tx_arbiter_if.slave: source
// handshakes, registered LPIF data/valid/irdy with trdy backpressure, stall_req/stall_ack,
// link_up, tlp_abort, packet counters).
// Optional macro LPIF_TX_PERF_CNT_EN enables the saturating tlp/dllp packet counters;
// without it both counter ports read 0.
module lpif_tx_arbiter #(
    parameter int DATA_BYTES     = 8,
    parameter int DLLP_BURST_MAX = 4
) (
    input logic              clk,
    input logic              reset,
    lpif_tx_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_TLP        = 2'd1;
    localparam logic [1:0] S_STALL_WAIT = 2'd2;
    localparam logic [1:0] S_STALLED    = 2'd3;
    localparam logic [3:0] BURST        = 4'(DLLP_BURST_MAX);

    logic [1:0]              state, state_nx;
    logic [3:0]              streak;
    logic                    idle_arb, cap, sel_dllp, tlp_gnt, dllp_gnt;
    logic                    irdy_q, abort_q;
    logic [DATA_BYTES*8-1:0] data_q;
    logic [DATA_BYTES-1:0]   valid_q;

    // DLLPs win at a packet boundary unless a waiting TLP has already seen a full DLLP burst.
    always_comb begin
        idle_arb = state == S_IDLE && !bus.stall_req;
        cap      = reset && bus.link_up && (!irdy_q || bus.trdy) && (idle_arb || state == S_TLP);
        sel_dllp = idle_arb && bus.dllp_req && !(bus.tlp_req && streak == BURST);
        tlp_gnt  = cap && !sel_dllp && bus.tlp_req;
        dllp_gnt = cap && sel_dllp;
    end

    // A DLLP grant never leaves IDLE, so a separate DLLP state is never occupied.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:       state_nx = bus.stall_req ? S_STALL_WAIT : (tlp_gnt && !bus.tlp_last) ? S_TLP : S_IDLE;
            S_TLP:        state_nx = (tlp_gnt && bus.tlp_last) ? (bus.stall_req ? S_STALL_WAIT : S_IDLE) : S_TLP;
            S_STALL_WAIT: state_nx = !bus.stall_req ? S_IDLE : !irdy_q ? S_STALLED : S_STALL_WAIT;
            default:      state_nx = bus.stall_req ? S_STALLED : S_IDLE;
        endcase
        if (!bus.link_up) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            streak  <= '0;
            irdy_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nx;
            abort_q <= !bus.link_up && state == S_TLP;
            if (!bus.link_up || tlp_gnt) streak <= '0;
            else if (dllp_gnt && streak != BURST) streak <= streak + 4'd1;
            if (!bus.link_up) begin
                irdy_q  <= 1'b0;
                data_q  <= '0;
                valid_q <= '0;
            end else if (tlp_gnt) begin
                irdy_q  <= 1'b1;
                data_q  <= bus.tlp_data;
                valid_q <= bus.tlp_valid;
            end else if (dllp_gnt) begin
                irdy_q  <= 1'b1;
                data_q  <= bus.dllp_data;
                valid_q <= bus.dllp_valid;
            end else if (bus.trdy) begin
                irdy_q  <= 1'b0;
            end
        end
    end

    assign bus.tlp_gnt   = tlp_gnt;
    assign bus.dllp_gnt  = dllp_gnt;
    assign bus.irdy      = irdy_q;
    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.stall_ack = state == S_STALLED;
    assign bus.tlp_abort = abort_q;

`ifdef LPIF_TX_PERF_CNT_EN
    logic [15:0] tlp_cnt, dllp_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tlp_cnt  <= '0;
            dllp_cnt <= '0;
        end else begin
            if (tlp_gnt && bus.tlp_last && tlp_cnt != 16'hFFFF) tlp_cnt <= tlp_cnt + 16'd1;
            if (dllp_gnt && dllp_cnt != 16'hFFFF) dllp_cnt <= dllp_cnt + 16'd1;
        end
    end

    assign bus.tlp_pkt_cnt  = tlp_cnt;
    assign bus.dllp_pkt_cnt = dllp_cnt;
`else
    assign bus.tlp_pkt_cnt  = '0;
    assign bus.dllp_pkt_cnt = '0;
`endif
endmodule
